// File: rtl/ldl_fifo_stream_reader_pkg.sv
// Shared constants and elaboration helpers for the LDL FIFO stream reader slice.
package ldl_fifo_pkg;

    // Largest FIFO read latency the reader is built to hide.
    localparam int unsigned RL_MAX = 4;

    // Bits needed to hold a count from 0 to n inclusive (never less than 1).
    function automatic int unsigned clog2_p1(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) <= 64'(n)) w = w + 1;
        return w;
    endfunction

    // The output buffer must absorb every word that can be in flight plus the one
    // being requested, otherwise the credit rule cannot hold.
    function automatic bit buf_depth_ok(input int unsigned buf_words, input int unsigned rl);
        return buf_words >= rl + 1;
    endfunction

endpackage

// File: rtl/ldl_fifo_stream_reader_if.sv
// FIFO read port plus valid/ready stream, seen from the reader (master) or its environment (slave).
interface ldl_fifo_stream_reader_if
    import ldl_fifo_pkg::*;
#(
    parameter int unsigned DW  = 8,
    parameter int unsigned BUF = 2
);
    localparam int unsigned LW = clog2_p1(BUF);

    logic          fifo_empty;
    logic          fifo_re;
    logic [DW-1:0] fifo_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [LW-1:0] level;

    modport master (
        input  fifo_empty, fifo_dout, m_ready,
        output fifo_re, m_valid, m_data, level
    );

    modport slave (
        output fifo_empty, fifo_dout, m_ready,
        input  fifo_re, m_valid, m_data, level
    );

endinterface

// File: rtl/ldl_fifo_stream_reader_buf.sv
// Circular register buffer: push at tail, pop at head, occupancy count, any depth >= 1.
module ldl_stream_buf
    import ldl_fifo_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         push,
    input  logic [DW-1:0]                push_data,
    input  logic                         pop,
    output logic [clog2_p1(DEPTH)-1:0]   occ,
    output logic [DW-1:0]                head
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW = clog2_p1(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          do_push, do_pop;

    // Next pointers/occupancy; pointers wrap by compare-and-clear so DEPTH need not be a power of 2.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        do_pop   = pop && (occ_q != '0);
        // A push into a full buffer is accepted only when the head leaves on the same edge.
        do_push  = push && ((occ_q != OW'(DEPTH)) || do_pop);
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Storage and pointer registers; contents cleared on reset so the head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/ldl_fifo_stream_reader.sv
// Read-side master for LDL synchronous FIFOs: issues reads on credit, absorbs the
// fixed read latency in a small buffer and presents the words as a valid/ready stream.
module ldl_fifo_stream_reader
    import ldl_fifo_pkg::*;
#(
    parameter int unsigned DW  = 8,
    parameter int unsigned RL  = 1,
    parameter int unsigned BUF = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    ldl_fifo_stream_reader_if.master   bus
);
    localparam int unsigned OW = clog2_p1(BUF);
    localparam int unsigned IW = clog2_p1(RL);
    localparam int unsigned SW = clog2_p1(BUF + RL + 1);

    generate
        if (RL < 1 || RL > RL_MAX) begin : g_bad_rl
            $error("ldl_fifo_stream_reader: RL=%0d outside 1..%0d", RL, RL_MAX);
        end
        if (!buf_depth_ok(BUF, RL)) begin : g_bad_buf
            $error("ldl_fifo_stream_reader: BUF=%0d must be >= RL+1 (RL=%0d)", BUF, RL);
        end
    endgenerate

    logic [RL-1:0] re_pipe_q, re_pipe_d;
    logic [IW-1:0] infl;
    logic [SW-1:0] credit_sum;
    logic [OW-1:0] occ;
    logic [DW-1:0] head;
    logic          pop;
    logic          ret;
    logic          re;

    // Count reads still travelling through the FIFO's read pipeline.
    always_comb begin
        infl = '0;
        for (int unsigned i = 0; i < RL; i++) infl = infl + IW'(re_pipe_q[i]);
    end

    // Credit check and in-flight pipe update. Buffered plus in-flight words, less the one
    // leaving this cycle, must stay below BUF, so every returning word finds a free slot.
    always_comb begin
        pop        = (occ != '0) && bus.m_ready;
        credit_sum = SW'(occ) + SW'(infl) - SW'(pop);
        re         = rst_n && !bus.fifo_empty && !flush && (credit_sum < SW'(BUF));
        ret        = re_pipe_q[RL-1];
        re_pipe_d  = '0;
        if (!flush) begin
            re_pipe_d[0] = re;
            for (int unsigned i = 1; i < RL; i++) re_pipe_d[i] = re_pipe_q[i-1];
        end
    end

    // In-flight read tracking; flush forgets every outstanding read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) re_pipe_q <= '0;
        else        re_pipe_q <= re_pipe_d;
    end

    ldl_stream_buf #(
        .DW    (DW),
        .DEPTH (BUF)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (flush),
        .push      (ret && !flush),
        .push_data (bus.fifo_dout),
        .pop       (pop && !flush),
        .occ       (occ),
        .head      (head)
    );

    assign bus.fifo_re = re;
    assign bus.m_valid = (occ != '0);
    assign bus.m_data  = head;
    assign bus.level   = occ;

endmodule

// File: tb/tb_ldl_fifo_stream_reader.sv
// Directed bench for ldl_fifo_stream_reader with FIFO models and scoreboards
// (RL=1/BUF=2 main instance, RL=3/BUF=4 second instance).
module tb_ldl_fifo_stream_reader;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush  = 1'b0;
    logic flush2 = 1'b0;

    always #5 clk = ~clk;

    ldl_fifo_stream_reader_if #(.DW(8), .BUF(2)) bus ();
    ldl_fifo_stream_reader_if #(.DW(8), .BUF(4)) bus2 ();

    ldl_fifo_stream_reader #(.DW(8), .RL(1), .BUF(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    ldl_fifo_stream_reader #(.DW(8), .RL(3), .BUF(4)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush2),
        .bus   (bus2)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] sb1 [$];
    logic [31:0] sb2 [$];

    // FIFO model 1: read latency 1
    logic [7:0]  mem1 [4096];
    int unsigned wr1 = 0;
    int unsigned rd1 = 0;
    logic        gate1 = 1'b0;
    logic [7:0]  dout1_q;
    assign bus.fifo_empty = (rd1 == wr1) || gate1;
    assign bus.fifo_dout  = dout1_q;
    always @(posedge clk) begin
        if (bus.fifo_re) begin
            dout1_q <= mem1[rd1[11:0]];
            rd1     <= rd1 + 1;
        end
    end

    // FIFO model 2: read latency 3
    logic [7:0]  mem2 [256];
    int unsigned wr2 = 0;
    int unsigned rd2 = 0;
    logic [7:0]  d2_q [3];
    assign bus2.fifo_empty = (rd2 == wr2);
    assign bus2.fifo_dout  = d2_q[2];
    always @(posedge clk) begin
        d2_q[0] <= mem2[rd2[7:0]];
        d2_q[1] <= d2_q[0];
        d2_q[2] <= d2_q[1];
        if (bus2.fifo_re) rd2 <= rd2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Stream monitor for instance 1: order against scoreboard plus read/level invariants.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.m_valid && bus.m_ready)
                check("m_data_order", {24'd0, bus.m_data},
                      (sb1.size() != 0) ? sb1.pop_front() : 32'hFFFF_FFFF);
            check("re_while_empty", {31'd0, bus.fifo_re & bus.fifo_empty}, 32'd0);
            check("level_le_2", {31'd0, bus.level <= 2'd2}, 32'd1);
        end
    end

    initial begin
        int cnt;
        int budget;

        bus.m_ready  = 1'b1;
        bus2.m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            mem1[i] = 8'(i);
            sb1.push_back(32'(i));
        end
        wr1 = 16;

        // 1: reset with a non-empty FIFO
        repeat (3) @(negedge clk);
        check("rst_fifo_re", {31'd0, bus.fifo_re}, 32'd0);
        check("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        check("rst_m_data",  {24'd0, bus.m_data},  32'd0);
        check("rst_level",   {30'd0, bus.level},   32'd0);
        check("rst_level2",  {29'd0, bus2.level},  32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 2: streaming, 16 reads back to back, valid two cycles after first read
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stream_re",    {31'd0, bus.fifo_re}, (i < 16) ? 32'd1 : 32'd0);
            check("stream_valid", {31'd0, bus.m_valid}, (i >= 2 && i < 18) ? 32'd1 : 32'd0);
        end
        check("stream_drained", sb1.size(), 32'd0);

        // 3: backpressure, only two reads outstanding
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem1[16 + i] = 8'(i);
            sb1.push_back(32'(i));
        end
        wr1 = 32;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.fifo_re) cnt++;
            if (i >= 3) check("bp_hold_data", {24'd0, bus.m_data}, 32'h00);
        end
        check("bp_reads",   cnt, 32'd2);
        check("bp_level",   {30'd0, bus.level}, 32'd2);
        check("bp_m_valid", {31'd0, bus.m_valid}, 32'd1);

        // 4: one pop frees a credit (read of 0x02), then flush with 0x01 buffered, 0x02 in flight
        @(posedge clk); #1 bus.m_ready = 1'b1;
        @(negedge clk);
        check("pop_frees_credit", {31'd0, bus.fifo_re}, 32'd1);
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("flush_re_off",    {31'd0, bus.fifo_re}, 32'd0);
        check("flush_pre_level", {30'd0, bus.level}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        void'(sb1.pop_front());
        void'(sb1.pop_front());
        @(negedge clk);
        check("flush_level",   {30'd0, bus.level}, 32'd0);
        check("flush_m_valid", {31'd0, bus.m_valid}, 32'd0);
        repeat (3) @(negedge clk);
        check("resume_data",  {24'd0, bus.m_data}, 32'h03);
        check("resume_level", {30'd0, bus.level}, 32'd2);
        @(posedge clk); #1 bus.m_ready = 1'b1;
        budget = 0;
        while (sb1.size() != 0 && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        check("bp_drained", sb1.size(), 32'd0);

        // 5: sparse FIFO and random consumer over 1000 words
        for (int i = 0; i < 1000; i++) begin
            mem1[32 + i] = 8'($urandom_range(0, 255));
            sb1.push_back({24'd0, mem1[32 + i]});
        end
        wr1 = 1032;
        budget = 0;
        while (sb1.size() != 0 && budget < 20000) begin
            @(posedge clk); #1;
            gate1       = 1'($urandom_range(0, 1));
            bus.m_ready = 1'($urandom_range(0, 1));
            budget++;
        end
        gate1 = 1'b0;
        bus.m_ready = 1'b1;
        check("sparse_drained", sb1.size(), 32'd0);

        // Async reset mid-transfer: everything drops at once
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
        mem1[1032 % 4096] = 8'hA5;
        mem1[1033 % 4096] = 8'h5A;
        wr1 = 1034;
        repeat (4) @(negedge clk);
        check("pre_areset_level", {30'd0, bus.level}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("areset_level",   {30'd0, bus.level}, 32'd0);
        check("areset_m_valid", {31'd0, bus.m_valid}, 32'd0);
        check("areset_m_data",  {24'd0, bus.m_data}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        bus.m_ready = 1'b1;

        // 6: RL=3, BUF=4 full throughput, valid four cycles after first read
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            mem2[i] = 8'(8'h40 + i);
            sb2.push_back(32'(8'h40 + i));
        end
        wr2 = 16;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            check("rl3_re",    {31'd0, bus2.fifo_re}, (i < 16) ? 32'd1 : 32'd0);
            check("rl3_valid", {31'd0, bus2.m_valid}, (i >= 4 && i < 20) ? 32'd1 : 32'd0);
            if (bus2.m_valid && bus2.m_ready)
                check("rl3_data", {24'd0, bus2.m_data},
                      (sb2.size() != 0) ? sb2.pop_front() : 32'hFFFF_FFFF);
        end
        check("rl3_drained", sb2.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
